// File: rtl/axi_sram_responder_if.sv
// Burst bus between the cache (initiator) and the SRAM responder.
// Carries the ar/r read channels and the aw/w/b write channels.
//   master : cache side, drives addresses, write data and the r/b readies
//   slave  : memory side, drives the address/data readies, read data and b_valid
interface axi_sram_responder_if;
  logic        io_ar_valid;
  logic        io_ar_ready;
  logic [63:0] io_ar_addr;
  logic [7:0]  io_ar_len;
  logic [2:0]  io_ar_size;
  logic [1:0]  io_ar_burst;
  logic        io_r_valid;
  logic        io_r_ready;
  logic [63:0] io_r_rdata;
  logic        io_r_last;
  logic        io_aw_valid;
  logic        io_aw_ready;
  logic [63:0] io_aw_addr;
  logic [7:0]  io_aw_len;
  logic [2:0]  io_aw_size;
  logic [1:0]  io_aw_burst;
  logic        io_w_valid;
  logic        io_w_ready;
  logic [63:0] io_w_data;
  logic [7:0]  io_w_strb;
  logic        io_w_last;
  logic        io_b_valid;
  logic        io_b_ready;

  modport master (
    output io_ar_valid, io_ar_addr, io_ar_len, io_ar_size, io_ar_burst,
    output io_r_ready,
    output io_aw_valid, io_aw_addr, io_aw_len, io_aw_size, io_aw_burst,
    output io_w_valid, io_w_data, io_w_strb, io_w_last,
    output io_b_ready,
    input  io_ar_ready, io_r_valid, io_r_rdata, io_r_last,
    input  io_aw_ready, io_w_ready, io_b_valid
  );

  modport slave (
    input  io_ar_valid, io_ar_addr, io_ar_len, io_ar_size, io_ar_burst,
    input  io_r_ready,
    input  io_aw_valid, io_aw_addr, io_aw_len, io_aw_size, io_aw_burst,
    input  io_w_valid, io_w_data, io_w_strb, io_w_last,
    input  io_b_ready,
    output io_ar_ready, io_r_valid, io_r_rdata, io_r_last,
    output io_aw_ready, io_w_ready, io_b_valid
  );
endinterface

// File: rtl/axi_sram_responder.sv
// Burst responder backing the cache with a word-addressed 64-bit array.
// Serves one read or write burst at a time; FIXED bursts reuse one word,
// everything else increments. Beat stride is always 8 bytes.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset (clears control and outputs, not memory)
//   bus   : slave side of the ar/r/aw/w/b burst interface
module axi_sram_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int RD_LAT    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  axi_sram_responder_if.slave    bus
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, RWAIT, RDATA, WDATA, WRESP} state_t;

  state_t             state, state_next;
  logic [63:0]        mem [MEM_WORDS];
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic [7:0]         len;
  logic [7:0]         count;
  logic               burst_fixed;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               r_valid;
  logic               r_last;
  logic [63:0]        r_rdata;
  logic               b_valid;
  logic               ar_ready;
  logic               aw_ready;
  logic               w_ready;
  logic               w_hs;
  logic               w_end;

  function automatic logic [IDX_W-1:0] word_index(input logic [63:0] addr);
    return addr[3 +: IDX_W];
  endfunction

  function automatic logic [IDX_W-1:0] advance(input logic [IDX_W-1:0] i,
                                               input logic fixed);
    return fixed ? i : i + IDX_W'(1);
  endfunction

  assign idx_next = advance(idx, burst_fixed);
  assign w_hs     = (state == WDATA) && bus.io_w_valid;
  // A burst closes on w_last or on reaching len, whichever is first.
  assign w_end    = w_hs && (bus.io_w_last || (count == len));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Readies are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    state_next = state;
    ar_ready   = 1'b0;
    aw_ready   = 1'b0;
    w_ready    = 1'b0;
    case (state)
      IDLE: begin
        aw_ready = reset;
        ar_ready = reset & ~bus.io_aw_valid;
        if (bus.io_aw_valid)      state_next = WDATA;
        else if (bus.io_ar_valid) state_next = RWAIT;
      end
      RWAIT: if (wait_cnt == '0) state_next = RDATA;
      RDATA: if (bus.io_r_ready && r_last) state_next = IDLE;
      WDATA: begin
        w_ready = reset;
        if (w_end) state_next = WRESP;
      end
      WRESP: if (bus.io_b_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      len         <= '0;
      count       <= '0;
      burst_fixed <= 1'b0;
      wait_cnt    <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_rdata     <= '0;
      b_valid     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.io_aw_valid) begin
            idx         <= word_index(bus.io_aw_addr);
            len         <= bus.io_aw_len;
            burst_fixed <= (bus.io_aw_burst == 2'b00);
            count       <= '0;
          end else if (bus.io_ar_valid) begin
            idx         <= word_index(bus.io_ar_addr);
            len         <= bus.io_ar_len;
            burst_fixed <= (bus.io_ar_burst == 2'b00);
            count       <= '0;
            wait_cnt    <= WAIT_W'(RD_LAT - 1);
          end
        end
        RWAIT: begin
          if (wait_cnt == '0) begin
            r_rdata <= mem[idx];
            r_valid <= 1'b1;
            r_last  <= (count == len);
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        RDATA: begin
          if (bus.io_r_ready) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end else begin
              // Fetch the following word now so the next beat has no bubble.
              count   <= count + 8'd1;
              idx     <= idx_next;
              r_rdata <= mem[idx_next];
              r_last  <= ((count + 8'd1) == len);
            end
          end
        end
        WDATA: begin
          if (w_hs) begin
            count <= count + 8'd1;
            idx   <= idx_next;
            if (w_end) b_valid <= 1'b1;
          end
        end
        WRESP: if (bus.io_b_ready) b_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_hs) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.io_w_strb[b]) mem[idx][8*b +: 8] <= bus.io_w_data[8*b +: 8];
      end
    end
  end

  assign bus.io_ar_ready = ar_ready;
  assign bus.io_aw_ready = aw_ready;
  assign bus.io_w_ready  = w_ready;
  assign bus.io_r_valid  = r_valid;
  assign bus.io_r_last   = r_last;
  assign bus.io_r_rdata  = r_rdata;
  assign bus.io_b_valid  = b_valid;

  // Size and out-of-range address bits are accepted but have no effect.
  logic unused_bits;
  assign unused_bits = ^{bus.io_ar_size, bus.io_aw_size,
                         bus.io_ar_addr[63:3+IDX_W], bus.io_ar_addr[2:0],
                         bus.io_aw_addr[63:3+IDX_W], bus.io_aw_addr[2:0]};

endmodule
